// File: rtl/timers_counter.sv
// Dual independent down-counter core: per-timer IDLE/COUNT control, reload, hardware gating and
// one-cycle terminal-count pulses. Optional per-timer 8-bit prescaler enabled by TIMERS_PRESCALER_EN.

module timers_counter_chan #(
  parameter int WIDTH = 32
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             en,
  input  logic             mode,
  input  logic             hwen,
  input  logic             ext_gate,
  input  logic [WIDTH-1:0] loadcount,
`ifdef TIMERS_PRESCALER_EN
  input  logic [7:0]       prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             irq
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] reload;
  logic             gate_ok;
  logic             prescale_ok;
  logic             tick;

  assign reload  = mode ? loadcount : {WIDTH{1'b1}};
  assign gate_ok = ~hwen | ext_gate;
  assign tick    = gate_ok & prescale_ok;

`ifdef TIMERS_PRESCALER_EN
  logic [7:0] psc;

  assign prescale_ok = (psc == prescale);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      psc <= 8'd0;
    end else if (state == ST_IDLE || !en) begin
      psc <= 8'd0;
    end else if (gate_ok) begin
      psc <= prescale_ok ? 8'd0 : psc + 8'd1;
    end
  end
`else
  assign prescale_ok = 1'b1;
`endif

  // Reload has priority over decrement, so the counter never wraps below zero.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= ST_IDLE;
      count <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (en) begin
            count <= reload;
            state <= ST_COUNT;
          end
        end
        default: begin
          if (!en) begin
            count <= '0;
            state <= ST_IDLE;
          end else if (tick) begin
            if (count == '0) begin
              count <= reload;
              irq   <= 1'b1;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

module timers_counter #(
  parameter int TIMER1_WIDTH = 32,
  parameter int TIMER2_WIDTH = 32
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [TIMER1_WIDTH-1:0] timer1loadcount,
  input  logic [TIMER2_WIDTH-1:0] timer2loadcount,
  input  logic [1:0]              timer_en,
  input  logic [1:0]              timer_mode,
  input  logic [1:0]              timer_hwen,
  input  logic [1:0]              timer_ext_gate,
`ifdef TIMERS_PRESCALER_EN
  input  logic [15:0]             timer_prescale,
`endif
  output logic [63:0]             bus_current_value,
  output logic [1:0]              bus_interrupts
);

  logic [TIMER1_WIDTH-1:0] count1;
  logic [TIMER2_WIDTH-1:0] count2;
  logic [31:0]             field1;
  logic [31:0]             field2;

  timers_counter_chan #(.WIDTH(TIMER1_WIDTH)) u_timer1 (
    .pclk      (pclk),
    .presetn   (presetn),
    .en        (timer_en[0]),
    .mode      (timer_mode[0]),
    .hwen      (timer_hwen[0]),
    .ext_gate  (timer_ext_gate[0]),
    .loadcount (timer1loadcount),
`ifdef TIMERS_PRESCALER_EN
    .prescale  (timer_prescale[7:0]),
`endif
    .count     (count1),
    .irq       (bus_interrupts[0])
  );

  timers_counter_chan #(.WIDTH(TIMER2_WIDTH)) u_timer2 (
    .pclk      (pclk),
    .presetn   (presetn),
    .en        (timer_en[1]),
    .mode      (timer_mode[1]),
    .hwen      (timer_hwen[1]),
    .ext_gate  (timer_ext_gate[1]),
    .loadcount (timer2loadcount),
`ifdef TIMERS_PRESCALER_EN
    .prescale  (timer_prescale[15:8]),
`endif
    .count     (count2),
    .irq       (bus_interrupts[1])
  );

  // Zero-extend each counter into its 32-bit field of the bus.
  always_comb begin
    field1 = '0;
    field2 = '0;
    field1[TIMER1_WIDTH-1:0] = count1;
    field2[TIMER2_WIDTH-1:0] = count2;
  end

  assign bus_current_value = {field2, field1};

endmodule
